// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: opcodes, immediate formats, immediate builder.
// Latency: n/a (types, constants and pure combinational functions only).
// Backpressure: n/a.
//
// Contents:
//   XLEN_DEFAULT  default datapath width
//   OPC_*         7-bit major opcodes used by the decode stage
//   imm_fmt_e     immediate encoding class of an opcode
//   imm_fmt_of()  opcode -> immediate class
//   gen_imm()     32-bit sign-extended immediate for any instruction word
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // B and J immediates are halfword offsets, so bit 0 is always zero.
  function automatic logic [31:0] gen_imm(input logic [31:0] inst);
    logic [31:0] imm;
    case (imm_fmt_of(inst[6:0]))
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// Register file, two combinational read ports, one write port with optional write-first bypass.
// Latency: reads 0 cycles; a write is visible to normal reads from the next cycle.
// Backpressure: none, the write port is accepted every cycle.
//
// Ports:
//   clk, rst_n            clock, async active-low reset (clears every entry)
//   rs1_idx/rs2_idx       read indices -> rs1_data/rs2_data
//   wr_en/wr_idx/wr_data  write port; index 0 is hardwired to zero
module regfile_bypass #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int WB_BYPASS = 1,
  parameter int RW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RW-1:0]   rs1_idx,
  input  logic [RW-1:0]   rs2_idx,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_idx,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_idx != '0)) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Index 0 is checked first, so a write to x0 can never leak through the bypass.
  always_comb begin
    rs1_data = mem_q[rs1_idx];
    if (rs1_idx == '0) begin
      rs1_data = '0;
    end else if ((WB_BYPASS != 0) && wr_en && (wr_idx == rs1_idx)) begin
      rs1_data = wr_data;
    end
  end

  always_comb begin
    rs2_data = mem_q[rs2_idx];
    if (rs2_idx == '0) begin
      rs2_data = '0;
    end else if ((WB_BYPASS != 0) && wr_en && (wr_idx == rs2_idx)) begin
      rs2_data = wr_data;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32IM decode stage: IF/ID register, immediate gen, regfile read, load-use interlock, ID/EX slot.
// Latency: 2 cycles fetch-to-ID/EX (1 extra bubble cycle after a dependent load).
// Backpressure: ex_ready low holds ID/EX; id_ready drops once IF/ID is full and cannot advance.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   if_valid/if_inst/if_pc       fetch side, accepted when if_valid && id_ready
//   id_ready                     stage can take a fetch word this cycle
//   flush                        drop both IF/ID and ID/EX contents at the next edge
//   wb_en/wb_rd/wb_data          register write-back
//   ex_ready                     execute takes the ID/EX slot when idex_valid && ex_ready
//   idex_*                       registered decoded instruction presented to execute
module id_stage_pipe
  import rv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int NREGS     = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid,
  input  logic [31:0]              if_inst,
  input  logic [XLEN-1:0]          if_pc,
  output logic                     id_ready,
  input  logic                     flush,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     ex_ready,
  output logic                     idex_valid,
  output logic [XLEN-1:0]          idex_pc,
  output logic [XLEN-1:0]          idex_rs1_data,
  output logic [XLEN-1:0]          idex_rs2_data,
  output logic [XLEN-1:0]          idex_imm,
  output logic [$clog2(NREGS)-1:0] idex_rs1,
  output logic [$clog2(NREGS)-1:0] idex_rs2,
  output logic [$clog2(NREGS)-1:0] idex_rd,
  output logic [6:0]               idex_opcode,
  output logic [2:0]               idex_func3,
  output logic [6:0]               idex_func7,
  output logic                     idex_is_load
);

  localparam int RW = $clog2(NREGS);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic            is_load;
  } idex_t;

  // ---------------- IF/ID holding register ----------------
  logic            ifid_valid_q, ifid_valid_d;
  logic [31:0]     ifid_inst_q,  ifid_inst_d;
  logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;

  // ---------------- ID/EX slot ----------------
  logic  idex_valid_q, idex_valid_d;
  idex_t idex_q, idex_d;
  idex_t dec;

  // ---------------- decode of the IF/ID word ----------------
  logic [6:0]      dec_opcode;
  logic [RW-1:0]   dec_rs1, dec_rs2, dec_rd;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
  logic            rs1_used, rs2_used;
  logic            hazard, slot_free, advance, fetch_xfer;

  // Upper index bits fall away naturally when RW < 5.
  assign dec_opcode = ifid_inst_q[6:0];
  assign dec_rs1    = ifid_inst_q[15 +: RW];
  assign dec_rs2    = ifid_inst_q[20 +: RW];
  assign dec_rd     = ifid_inst_q[7 +: RW];
  assign dec_imm32  = gen_imm(ifid_inst_q);

  assign rs1_used = !((dec_opcode == OPC_LUI) || (dec_opcode == OPC_AUIPC) ||
                      (dec_opcode == OPC_JAL));
  assign rs2_used = (dec_opcode == OPC_OP) || (dec_opcode == OPC_STORE) ||
                    (dec_opcode == OPC_BRANCH);

  regfile_bypass #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .WB_BYPASS (WB_BYPASS),
    .RW        (RW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_idx  (dec_rs1),
    .rs2_idx  (dec_rs2),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data),
    .wr_en    (wb_en),
    .wr_idx   (wb_rd),
    .wr_data  (wb_data)
  );

  // A load sitting in ID/EX cannot forward its result in time for the
  // instruction right behind it; hold that instruction for one cycle.
  assign hazard = ifid_valid_q && idex_valid_q && idex_q.is_load && (idex_q.rd != '0) &&
                  ((rs1_used && (dec_rs1 == idex_q.rd)) ||
                   (rs2_used && (dec_rs2 == idex_q.rd)));

  assign slot_free  = !idex_valid_q || ex_ready;
  assign advance    = ifid_valid_q && !hazard && slot_free;
  assign id_ready   = !ifid_valid_q || advance;
  assign fetch_xfer = if_valid && id_ready;

  always_comb begin
    dec          = '0;
    dec.pc       = ifid_pc_q;
    dec.rs1_data = rf_rs1_data;
    dec.rs2_data = rf_rs2_data;
    dec.imm      = XLEN'($signed(dec_imm32));
    dec.rs1      = dec_rs1;
    dec.rs2      = dec_rs2;
    dec.rd       = dec_rd;
    dec.opcode   = dec_opcode;
    dec.func3    = ifid_inst_q[14:12];
    dec.func7    = ifid_inst_q[31:25];
    dec.is_load  = (dec_opcode == OPC_LOAD);
  end

  // Flush outranks everything, including a fetch landing on the same edge.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
    end else if (fetch_xfer) begin
      ifid_valid_d = 1'b1;
      ifid_inst_d  = if_inst;
      ifid_pc_d    = if_pc;
    end else if (advance) begin
      ifid_valid_d = 1'b0;
    end
  end

  // A free slot with no advance (empty IF/ID or hazard) becomes a bubble;
  // the data fields keep their old contents in that case.
  always_comb begin
    idex_valid_d = idex_valid_q;
    idex_d       = idex_q;
    if (flush) begin
      idex_valid_d = 1'b0;
    end else if (slot_free) begin
      idex_valid_d = advance;
      if (advance) begin
        idex_d = dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= '0;
      ifid_pc_q    <= '0;
      idex_valid_q <= 1'b0;
      idex_q       <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      idex_valid_q <= idex_valid_d;
      idex_q       <= idex_d;
    end
  end

  assign idex_valid    = idex_valid_q;
  assign idex_pc       = idex_q.pc;
  assign idex_rs1_data = idex_q.rs1_data;
  assign idex_rs2_data = idex_q.rs2_data;
  assign idex_imm      = idex_q.imm;
  assign idex_rs1      = idex_q.rs1;
  assign idex_rs2      = idex_q.rs2;
  assign idex_rd       = idex_q.rd;
  assign idex_opcode   = idex_q.opcode;
  assign idex_func3    = idex_q.func3;
  assign idex_func7    = idex_q.func7;
  assign idex_is_load  = idex_q.is_load;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: two instances (bypass on / off) share all inputs.
// Latency: n/a.
// Backpressure: ex_ready is driven per step to exercise stall and release.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
  logic        flush, wb_en, ex_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        id_ready, idex_valid, idex_is_load;
  logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [6:0]  idex_opcode, idex_func7;
  logic [2:0]  idex_func3;

  logic        nb_id_ready, nb_idex_valid, nb_idex_is_load;
  logic [31:0] nb_idex_pc, nb_idex_rs1_data, nb_idex_rs2_data, nb_idex_imm;
  logic [4:0]  nb_idex_rs1, nb_idex_rs2, nb_idex_rd;
  logic [6:0]  nb_idex_opcode, nb_idex_func7;
  logic [2:0]  nb_idex_func3;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .NREGS(32), .WB_BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .idex_valid(idex_valid), .idex_pc(idex_pc),
    .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_opcode(idex_opcode),
    .idex_func3(idex_func3), .idex_func7(idex_func7), .idex_is_load(idex_is_load)
  );

  id_stage_pipe #(.XLEN(32), .NREGS(32), .WB_BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(nb_id_ready), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .idex_valid(nb_idex_valid), .idex_pc(nb_idex_pc),
    .idex_rs1_data(nb_idex_rs1_data), .idex_rs2_data(nb_idex_rs2_data), .idex_imm(nb_idex_imm),
    .idex_rs1(nb_idex_rs1), .idex_rs2(nb_idex_rs2), .idex_rd(nb_idex_rd),
    .idex_opcode(nb_idex_opcode), .idex_func3(nb_idex_func3), .idex_func7(nb_idex_func7),
    .idex_is_load(nb_idex_is_load)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] d1b1, d2b1;  // operands expected from the bypassing instance
    logic [31:0] d1b0, d2b0;  // operands expected from the non-bypassing instance
  } exp_t;

  exp_t        sb[$];
  exp_t        pend;
  logic [31:0] mdl [32];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_underflow observed=extra_issue pc=%h expected=none", idex_pc);
      return;
    end
    e = sb.pop_front();
    chk("pc", idex_pc, e.pc);
    chk("imm", idex_imm, e.imm);
    chk("rs1_data", idex_rs1_data, e.d1b1);
    chk("rs2_data", idex_rs2_data, e.d2b1);
    chk("rs1", 32'(idex_rs1), 32'(e.inst[19:15]));
    chk("rs2", 32'(idex_rs2), 32'(e.inst[24:20]));
    chk("rd", 32'(idex_rd), 32'(e.inst[11:7]));
    chk("opcode", 32'(idex_opcode), 32'(e.inst[6:0]));
    chk("func3", 32'(idex_func3), 32'(e.inst[14:12]));
    chk("func7", 32'(idex_func7), 32'(e.inst[31:25]));
    chk("is_load", 32'(idex_is_load), 32'(e.inst[6:0] == 7'b0000011));
    chk("nb_valid", 32'(nb_idex_valid), 32'd1);
    chk("nb_pc", nb_idex_pc, e.pc);
    chk("nb_imm", nb_idex_imm, e.imm);
    chk("nb_rs1_data", nb_idex_rs1_data, e.d1b0);
    chk("nb_rs2_data", nb_idex_rs2_data, e.d2b0);
    chk("nb_idx", {17'd0, nb_idex_rs1, nb_idex_rs2, nb_idex_rd}, {17'd0, e.inst[19:15], e.inst[24:20], e.inst[11:7]});
    chk("nb_ctl", {14'd0, nb_idex_opcode, nb_idex_func3, nb_idex_func7, nb_idex_is_load},
        {14'd0, e.inst[6:0], e.inst[14:12], e.inst[31:25], e.inst[6:0] == 7'b0000011});
  endtask

  // One cycle: settle inputs, account EX/fetch transfers for the coming edge, advance.
  task automatic tick();
    logic acc;
    #1;
    if (idex_valid && ex_ready) pop_check();
    acc = if_valid && id_ready && !flush;
    if (acc) sb.push_back(pend);
    @(posedge clk);
    #1;
    if (acc) if_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_fetch(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] imm);
    if_inst   = inst;
    if_pc     = pc;
    if_valid  = 1'b1;
    pend.inst = inst;
    pend.pc   = pc;
    pend.imm  = imm;
    pend.d1b1 = mdl[inst[19:15]];
    pend.d2b1 = mdl[inst[24:20]];
    pend.d1b0 = mdl[inst[19:15]];
    pend.d2b0 = mdl[inst[24:20]];
  endtask

  task automatic wait_accept();
    int n = 0;
    while (if_valid && (n < 20)) begin
      tick();
      n++;
    end
    if (if_valid) begin
      checks++;
      failures++;
      $error("FAIL fetch_timeout observed=not_accepted pc=%h expected=accepted", if_pc);
      if_valid = 1'b0;
    end
  endtask

  task automatic drive_fetch(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] imm);
    set_fetch(inst, pc, imm);
    wait_accept();
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_rd   = rd;
    wb_data = data;
    tick();
    wb_en = 1'b0;
    if (rd != 5'd0) mdl[rd] = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    #12;
    chk("rst_idex_valid", 32'(idex_valid), 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    chk("rst_idex_pc", idex_pc, 32'd0);
    chk("rst_idex_imm", idex_imm, 32'd0);
    chk("rst_idex_rs1_data", idex_rs1_data, 32'd0);
    chk("rst_nb_idex_valid", 32'(nb_idex_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    wb_write(5'd2, 32'h0000_0100);
    wb_write(5'd7, 32'h0000_0077);
    wb_write(5'd8, 32'h0000_0088);

    // ADDI x1,x0,-5
    drive_fetch(32'hFFB00093, 32'h0000_0000, 32'hFFFF_FFFB);
    tick();
    chk("addi_valid", 32'(idex_valid), 32'd1);
    chk("addi_imm", idex_imm, 32'hFFFF_FFFB);
    chk("addi_rd", 32'(idex_rd), 32'd1);
    chk("addi_rs1_data", idex_rs1_data, 32'd0);
    idle(2);

    // LW x5,0(x2) ; ADD x6,x5,x7 -> one bubble
    drive_fetch(32'h00012283, 32'h0000_0004, 32'h0);
    drive_fetch(32'h00728333, 32'h0000_0008, 32'h0);
    chk("lu_stall_ready", 32'(id_ready), 32'd0);
    chk("lu_lw_in_ex", 32'(idex_is_load), 32'd1);
    tick();
    chk("lu_bubble", 32'(idex_valid), 32'd0);
    chk("lu_ready_after", 32'(id_ready), 32'd1);
    tick();
    chk("lu_add_issued", 32'(idex_valid), 32'd1);
    chk("lu_add_rs1", 32'(idex_rs1), 32'd5);
    idle(2);

    // LW x5,0(x2) ; ADD x6,x8,x7 -> no stall
    drive_fetch(32'h00012283, 32'h0000_0010, 32'h0);
    drive_fetch(32'h00740333, 32'h0000_0014, 32'h0);
    chk("nolu_ready", 32'(id_ready), 32'd1);
    tick();
    chk("nolu_issued", 32'(idex_valid), 32'd1);
    chk("nolu_rs1", 32'(idex_rs1), 32'd8);
    idle(2);

    // ADD x4,x3,x3 with write-back to x3 in its decode cycle
    set_fetch(32'h00318233, 32'h0000_0020, 32'h0);
    pend.d1b1 = 32'hDEAD_BEEF;
    pend.d2b1 = 32'hDEAD_BEEF;
    wait_accept();
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_en = 1'b0;
    mdl[3] = 32'hDEAD_BEEF;
    chk("byp_rs1_data", idex_rs1_data, 32'hDEAD_BEEF);
    chk("nobyp_rs2_data", nb_idex_rs2_data, 32'd0);
    idle(2);

    // writes to x0 are dropped and never bypassed
    wb_write(5'd0, 32'h0000_1234);
    drive_fetch(32'h000004B3, 32'h0000_0024, 32'h0);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_5678;
    tick();
    wb_en = 1'b0;
    chk("x0_rs1_data", idex_rs1_data, 32'd0);
    idle(2);

    // execute back-pressure for 3 cycles
    drive_fetch(32'h00100513, 32'h0000_0030, 32'h1);
    drive_fetch(32'h00200593, 32'h0000_0034, 32'h2);
    ex_ready = 1'b0;
    set_fetch(32'h00300613, 32'h0000_0038, 32'h3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", 32'(id_ready), 32'd0);
      chk("stall_valid", 32'(idex_valid), 32'd1);
      chk("stall_pc", idex_pc, 32'h0000_0030);
      chk("stall_imm", idex_imm, 32'h1);
    end
    ex_ready = 1'b1;
    wait_accept();
    drive_fetch(32'h00400693, 32'h0000_003C, 32'h4);
    idle(4);

    // flush with both slots full and a fetch pending
    ex_ready = 1'b0;
    drive_fetch(32'h00500713, 32'h0000_0040, 32'h5);
    drive_fetch(32'h00600793, 32'h0000_0044, 32'h6);
    chk("fl_pre_valid", 32'(idex_valid), 32'd1);
    chk("fl_pre_ready", 32'(id_ready), 32'd0);
    set_fetch(32'h00700813, 32'h0000_0048, 32'h7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if_valid = 1'b0;
    chk("fl_idex_valid", 32'(idex_valid), 32'd0);
    chk("fl_ifid_empty", 32'(id_ready), 32'd1);
    chk("fl_nb_idex_valid", 32'(nb_idex_valid), 32'd0);
    sb.delete();
    ex_ready = 1'b1;
    tick();
    chk("fl_stays_empty", 32'(idex_valid), 32'd0);

    // JAL x1,+0x800 ; BEQ x0,x0,-4
    drive_fetch(32'h001000EF, 32'h0000_0050, 32'h0000_0800);
    drive_fetch(32'hFE000EE3, 32'h0000_0054, 32'hFFFF_FFFC);
    chk("jal_imm", idex_imm, 32'h0000_0800);
    tick();
    chk("beq_imm", idex_imm, 32'hFFFF_FFFC);
    idle(2);

    // reset in the middle of traffic
    ex_ready = 1'b0;
    drive_fetch(32'h00740333, 32'h0000_0060, 32'h0);
    tick();
    set_fetch(32'h00100513, 32'h0000_0064, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(idex_valid), 32'd0);
    chk("mid_rst_ready", 32'(id_ready), 32'd1);
    chk("mid_rst_pc", idex_pc, 32'd0);
    if_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    @(posedge clk);
    #1;
    drive_fetch(32'h00740333, 32'h0000_0068, 32'h0);
    idle(3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Pipelined RV32IM instruction-decode stage: IF/ID holding register, full-format immediate generator, parametrised register file with write-back bypass, load-use interlock, and a registered ID/EX output slot.
- Sits between fetch (valid/ready handshake in) and execute (valid/ready handshake out, so multi-cycle MUL/DIV can back-pressure).
- Write-back arrives on a dedicated port.
- Successor to the combinational decode stage: adds clocking, stalls, flush and all five immediate formats.

Parameters:
- XLEN, 32, data/PC/immediate width
- NREGS, 32, architectural register count (power of two, 2..32); index width RW = clog2(NREGS)
- WB_BYPASS, 1, 1 = same-cycle write-back forwarded into decode read; 0 = read returns old value

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents instruction
- if_inst  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- id_ready  out  1  stage accepts if_inst this cycle
- flush  in  1  kill all in-flight decode state (branch/jump redirect)
- wb_en  in  1  register write enable
- wb_rd  in  RW  write index
- wb_data  in  XLEN  write data
- ex_ready  in  1  execute accepts ID/EX slot
- idex_valid  out  1  ID/EX slot holds an instruction
- idex_pc  out  XLEN  PC
- idex_rs1_data, idex_rs2_data  out  XLEN  operands
- idex_imm  out  XLEN  sign-extended immediate
- idex_rs1, idex_rs2, idex_rd  out  RW  register indices
- idex_opcode  out  7  opcode
- idex_func3  out  3  func3
- idex_func7  out  7  func7
- idex_is_load  out  1  opcode == LOAD

Behaviour:
- Reset (async, rst_n=0):
  - ifid_valid=0, idex_valid=0.
  - All idex_* data outputs and all register-file entries = 0.
- Handshake:
  - Fetch transfer when if_valid && id_ready.
  - EX transfer when idex_valid && ex_ready.
- Definitions:
  - slot_free = !idex_valid || ex_ready.
  - hazard = ifid_valid && idex_valid && idex_is_load && idex_rd!=0 && ((rs1_used && rs1==idex_rd) || (rs2_used && rs2==idex_rd)).
  - advance = ifid_valid && !hazard && slot_free.
- id_ready = !ifid_valid || advance (combinational).
- IF/ID register:
  - On fetch transfer: load inst/pc, ifid_valid=1.
  - Else if advance: ifid_valid=0.
  - Else: hold.
- ID/EX register:
  - When slot_free: idex_valid <= advance, and on advance load all idex_* fields.
  - When hazard && slot_free: bubble (idex_valid=0; data fields don't-care, hold).
  - When !slot_free: hold everything.
- Load-use latency: dependent instruction issues exactly one cycle late, provided ex_ready=1.
- Flush: next edge sets ifid_valid=0 and idex_valid=0; a simultaneous fetch transfer is discarded. Flush has priority over all other updates.
- Operand usage:
  - rs1_used is 0 for LUI, AUIPC and JAL; 1 otherwise.
  - rs2_used is 1 for OP(0110011), STORE and BRANCH; 0 otherwise.
- Immediate by opcode, sign-extended to XLEN:
  - I-type: LOAD 0000011, OP-IMM 0010011, JALR 1100111.
  - S-type: 0100011.
  - B-type: 1100011 (bit0=0).
  - U-type: LUI 0110111, AUIPC 0010111 ({inst[31:12],12'b0}).
  - J-type: 1101111 (bit0=0).
  - Any other opcode → imm=0.
- Register file:
  - NREGS×XLEN, two combinational read ports, one synchronous write port.
  - Writes with wb_rd==0 are ignored; reads of index 0 return 0.
  - Bypass: if WB_BYPASS && wb_en && wb_rd!=0 && wb_rd==rs, the read returns wb_data in the same cycle.
  - Operands are re-read every cycle while stalled, so a write-back landing during a stall is captured.
- Index slicing: rs1=inst[15:15+RW-1], rs2=inst[20+:RW], rd=inst[7+:RW]. Upper index bits are ignored when RW<5.
- Reset mid-operation: all pipeline state is dropped; no partial transfer.

Decomposition:
- Package rv_pkg:
  - XLEN default.
  - Opcode constants (OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP).
  - Enum imm_fmt_e {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}.
- Sub-modules:
  - regfile_bypass (parametrised register file with write-first bypass), instantiated once.
  - Immediate generation stays a combinational function in rv_pkg.

Test Plan:
- Reset then ADDI x1,x0,-5 (0xFFB00093) with ex_ready=1 → one cycle later idex_valid=1, idex_imm=0xFFFFFFFB, idex_rd=1, idex_rs1_data=0.
- LW x5,0(x2) followed by ADD x6,x5,x7 → ADD held one cycle: id_ready=0 and idex_valid=0 bubble, then ADD issues. No stall when the ADD uses x8 instead of x5.
- WB_BYPASS=1: wb_en=1, wb_rd=3, wb_data=0xDEADBEEF in the same cycle ADD x4,x3,x3 decodes → idex_rs1_data=idex_rs2_data=0xDEADBEEF. With WB_BYPASS=0 → old value 0.
- wb_en=1, wb_rd=0, wb_data=0x1234 then read x0 → 0.
- ex_ready=0 for 3 cycles with a stream of instructions → idex_* stable, id_ready=0 once IF/ID is full, no instruction lost or duplicated after release.
- flush asserted with both slots valid and if_valid=1 → next cycle idex_valid=0 and ifid empty; the following fetched instruction emerges normally. JAL imm 0x800 and BEQ imm -4 decode to 0x00000800 and 0xFFFFFFFC.
